max_net_arbiter: RTL and testbench

MAX_NET_ARBITER -- requirements
Module: max_net_arbiter

---
 rtl/max_net_arbiter.sv | 123 ++++++++++++
 tb/tb_max_net_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/max_net_arbiter.sv
// Two-client front end for a shared max_net: grants one job at a time
// (round-robin on contention), launches it, and returns the result or a timeout.
module max_net_arbiter #(
  parameter int TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_0,
  input  logic         req_1,
  input  logic [127:0] req_x_0,
  input  logic [127:0] req_x_1,
  output logic         ack_0,
  output logic         ack_1,
  output logic         resp_valid_0,
  output logic         resp_valid_1,
  output logic [3:0]   resp_out,
  output logic         resp_err,
  output logic         busy,
  output logic [31:0]  mn_x_1,
  output logic [31:0]  mn_x_2,
  output logic [31:0]  mn_x_3,
  output logic [31:0]  mn_x_4,
  output logic         mn_start,
  input  logic         mn_done,
  input  logic [3:0]   mn_out
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          last_grant, last_grant_next;
  logic [127:0]  ops, ops_next;
  logic [15:0]   timer, timer_next;
  logic [3:0]    result, result_next;
  logic          err, err_next;
  logic          grant_sel;

  // On contention the client that did not win last time is chosen.
  assign grant_sel = (req_0 && req_1) ? ~last_grant : req_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ops        <= '0;
      timer      <= '0;
      result     <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
      ops        <= ops_next;
      timer      <= timer_next;
      result     <= result_next;
      err        <= err_next;
    end
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;
    ops_next        = ops;
    timer_next      = timer;
    result_next     = result;
    err_next        = err;
    case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          state_next      = LAUNCH;
          owner_next      = grant_sel;
          last_grant_next = grant_sel;
          ops_next        = grant_sel ? req_x_1 : req_x_0;
        end
      end
      LAUNCH: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A completion on the timeout cycle still counts as a normal result.
        if (mn_done) begin
          result_next = mn_out;
          err_next    = 1'b0;
          state_next  = RESP;
        end else begin
          timer_next = timer + 16'd1;
          if (timer == TIMEOUT_LAST) begin
            result_next = 4'b0000;
            err_next    = 1'b1;
            state_next  = RESP;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign mn_start     = (state == LAUNCH);
  assign ack_0        = (state == LAUNCH) && !owner;
  assign ack_1        = (state == LAUNCH) && owner;
  assign resp_valid_0 = (state == RESP) && !owner;
  assign resp_valid_1 = (state == RESP) && owner;
  assign resp_out     = (state == RESP) ? result : 4'b0000;
  assign resp_err     = (state == RESP) && err;

  assign mn_x_1 = ops[31:0];
  assign mn_x_2 = ops[63:32];
  assign mn_x_3 = ops[95:64];
  assign mn_x_4 = ops[127:96];

endmodule

// File: tb/tb_max_net_arbiter.sv
// Self-checking bench for max_net_arbiter: a directed job table, reset-abort
// sequence and randomized jobs predicted from the arbitration/timeout rules.
module tb_max_net_arbiter;

  localparam int TIMEOUT = 8;

  logic         clk;
  logic         rst;
  logic         req_0, req_1;
  logic [127:0] req_x_0, req_x_1;
  logic         ack_0, ack_1;
  logic         resp_valid_0, resp_valid_1;
  logic [3:0]   resp_out;
  logic         resp_err;
  logic         busy;
  logic [31:0]  mn_x_1, mn_x_2, mn_x_3, mn_x_4;
  logic         mn_start;
  logic         mn_done;
  logic [3:0]   mn_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic model_last;

  max_net_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1),
    .req_x_0(req_x_0), .req_x_1(req_x_1),
    .ack_0(ack_0), .ack_1(ack_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_out(resp_out), .resp_err(resp_err), .busy(busy),
    .mn_x_1(mn_x_1), .mn_x_2(mn_x_2), .mn_x_3(mn_x_3), .mn_x_4(mn_x_4),
    .mn_start(mn_start), .mn_done(mn_done), .mn_out(mn_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [127:0] x0;
    logic [127:0] x1;
    int           d;
    logic [3:0]   val;
    logic         noise;
    logic         glitch;
    logic         exp_client;
    logic [3:0]   exp_out;
    logic         exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete job from an idle DUT: d is the number of WAIT cycles with
  // mn_done low before the emulated max_net raises it.
  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [127:0] x0, input logic [127:0] x1,
                               input int d, input logic [3:0] val,
                               input logic noise, input logic glitch,
                               input logic exp_client, input logic [3:0] exp_out,
                               input logic exp_err);
    logic [127:0] xe;
    int exp_k;
    int guard;
    xe    = exp_client ? x1 : x0;
    exp_k = (d < TIMEOUT) ? d : TIMEOUT - 1;
    req_0 = r0; req_1 = r1; req_x_0 = x0; req_x_1 = x1;
    mn_done = noise; mn_out = ~val;
    step;
    checkOutput("ack_0", ack_0, !exp_client);
    checkOutput("ack_1", ack_1, exp_client);
    checkOutput("mn_start", mn_start, 1'b1);
    checkOutput("mn_x_launch", {mn_x_4, mn_x_3, mn_x_2, mn_x_1}, xe);
    if (exp_client) req_1 = 1'b0; else req_0 = 1'b0;
    step;
    for (int k = 0; k <= exp_k; k++) begin
      checkOutput("wait_quiet", {ack_0, ack_1, mn_start, resp_valid_0, resp_valid_1, busy}, 6'b000001);
      if (glitch && k == 1) req_1 = 1'b1;
      if (glitch && k == 2) req_1 = 1'b0;
      mn_done = (k >= d);
      mn_out  = (k >= d) ? val : ~val;
      step;
    end
    checkOutput("resp_valid_0", resp_valid_0, !exp_client);
    checkOutput("resp_valid_1", resp_valid_1, exp_client);
    checkOutput("resp_out", resp_out, exp_out);
    checkOutput("resp_err", resp_err, exp_err);
    checkOutput("mn_x_resp", {mn_x_4, mn_x_3, mn_x_2, mn_x_1}, xe);
    mn_done = 1'b0;
    step;
    guard = 0;
    while (busy && guard < 2 * TIMEOUT + 8) begin
      step;
      guard++;
    end
    checkOutput("return_idle", {busy, resp_valid_0, resp_valid_1}, 3'b000);
    if (busy) begin
      rst = 1'b1; step; rst = 1'b0; step;
      model_last = 1'b1;
    end else begin
      model_last = exp_client;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] op_a, op_b, op_c, op_d, op_035;
    op_a   = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    op_b   = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
    op_c   = {32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008};
    op_d   = {32'hffffffff, 32'h00000000, 32'h80000000, 32'h7fffffff};
    op_035 = {32'd7, 32'd2, 32'd9, 32'd4};

    tbl[0] = '{1'b1, 1'b1, op_a,   op_b,   2,  4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0};
    tbl[1] = '{1'b1, 1'b1, op_c,   op_d,   3,  4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, op_a,   op_b,   1,  4'h2, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0};
    tbl[3] = '{1'b1, 1'b1, op_c,   op_d,   0,  4'h8, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0};
    tbl[4] = '{1'b1, 1'b0, op_035, '0,     4,  4'h2, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0};
    tbl[5] = '{1'b0, 1'b1, '0,     op_b,   20, 4'h5, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, op_a,   '0,     7,  4'h8, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0};
    tbl[7] = '{1'b0, 1'b1, '0,     '0,     0,  4'h1, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, op_c,   '0,     8,  4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, op_d,   '0,     6,  4'h3, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0};

    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; req_x_0 = '0; req_x_1 = '0;
    mn_done = 1'b0; mn_out = 4'h0;
    model_last = 1'b1;
    step; step;
    checkOutput("reset_ctrl", {ack_0, ack_1, resp_valid_0, resp_valid_1, mn_start, busy, resp_err}, 7'b0);
    checkOutput("reset_resp_out", resp_out, 4'h0);
    checkOutput("reset_mn_x", {mn_x_4, mn_x_3, mn_x_2, mn_x_1}, 128'h0);
    rst = 1'b0;
    step;
    checkOutput("idle_after_reset", busy, 1'b0);

    $display("[TB] directed job table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].r0, tbl[i].r1, tbl[i].x0, tbl[i].x1, tbl[i].d, tbl[i].val,
                    tbl[i].noise, tbl[i].glitch, tbl[i].exp_client, tbl[i].exp_out, tbl[i].exp_err);
    end
    checkOutput("mn_x_2_zero_job_kept", mn_x_2, 32'h00000000 ^ op_d[63:32]);
    req_0 = 1'b0; req_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput("dropped_req_1", {ack_1, resp_valid_1, busy}, 3'b000);
    end

    $display("[TB] reset during WAIT");
    req_0 = 1'b1; req_x_0 = op_a;
    step;
    checkOutput("abort_ack_0", ack_0, 1'b1);
    req_0 = 1'b0;
    step; step; step;
    checkOutput("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("abort_async", {busy, resp_valid_0, resp_valid_1, ack_0, mn_start}, 5'b0);
    checkOutput("abort_mn_x", {mn_x_4, mn_x_3, mn_x_2, mn_x_1}, 128'h0);
    step;
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput("abort_no_resp", {busy, resp_valid_0, resp_valid_1}, 3'b000);
    end
    applyStimulus(1'b0, 1'b1, '0, op_b, 3, 4'h6, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0);

    $display("[TB] randomized jobs");
    for (int i = 0; i < 30; i++) begin
      int pat, d;
      logic r0, r1, cl, e_err, noise;
      logic [127:0] x0, x1;
      logic [3:0] val, e_out;
      pat   = $urandom_range(1, 3);
      r0    = pat[0];
      r1    = pat[1];
      x0    = {$urandom, $urandom, $urandom, $urandom};
      x1    = {$urandom, $urandom, $urandom, $urandom};
      d     = $urandom_range(0, TIMEOUT + 2);
      val   = 4'($urandom);
      noise = 1'($urandom);
      cl    = (r0 && r1) ? !model_last : r1;
      e_err = (d >= TIMEOUT);
      e_out = e_err ? 4'h0 : val;
      applyStimulus(r0, r1, x0, x1, d, val, noise, 1'b0, cl, e_out, e_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
